// File: rtl/mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_pkg : shared types, constants and address decode for mem_dualport     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } port_state_e;

  localparam int LAT_W = $clog2(4);
  localparam int DEC_W = 64;

  typedef struct packed {
    logic             err;
    logic [DEC_W-1:0] idx;
  } decode_t;

  // Offset is taken modulo 2**xlen so addresses below the base wrap high and fail the range test.
  function automatic decode_t addr_decode(input logic [DEC_W-1:0] addr,
                                          input logic [DEC_W-1:0] base,
                                          input int unsigned      depth_words,
                                          input int unsigned      xlen);
    logic [DEC_W-1:0] mask;
    logic [DEC_W-1:0] off;
    int unsigned      blog2;
    decode_t          r;
    blog2 = $clog2(xlen / 8);
    mask  = (xlen >= DEC_W) ? '1 : ((64'd1 << xlen) - 64'd1);
    off   = (addr - base) & mask;
    r.idx = off >> blog2;
    r.err = ((addr & ((64'd1 << blog2) - 64'd1)) != 64'd0) ||
            (off >= (64'(depth_words) * 64'(xlen / 8)));
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_fsm : request/response handshake engine for one memory port     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_port_fsm
  import mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  output logic            hs_o,
  input  logic [XLEN-1:0] rdata_i,
  input  logic            err_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_data_o,
  output logic            resp_err_o
);

  localparam logic [LAT_W-1:0] LAST_WAIT = LAT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

  port_state_e      state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic             err_q, err_d;
  logic             hs;

  assign hs = req_valid_i && req_ready_o && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Response payload is captured only at the handshake, so it holds through WAIT and RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hs) begin
          data_d  = rdata_i;
          err_d   = err_i;
          cnt_d   = '0;
          state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == LAST_WAIT) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + LAT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = (state_q == ST_IDLE);
    resp_valid_o = (state_q == ST_RESP);
  end

  assign hs_o        = hs;
  assign resp_data_o = data_q;
  assign resp_err_o  = err_q;

endmodule
`default_nettype wire

// File: rtl/mem_dualport.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_dualport : unified memory with independent fetch and data ports      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_dualport
  import mem_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              DEPTH_WORDS = 1024,
  parameter int              LATENCY     = 1,
  parameter logic [XLEN-1:0] BASE_ADDR   = XLEN'(32'h8000_0000),
  parameter string           INIT_FILE   = "",
  localparam int             BYTES       = XLEN / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req_valid,
  output logic             if_req_ready,
  input  logic [XLEN-1:0]  if_req_addr,
  output logic             if_resp_valid,
  input  logic             if_resp_ready,
  output logic [XLEN-1:0]  if_resp_inst,
  output logic             if_resp_err,
  input  logic             dm_req_valid,
  output logic             dm_req_ready,
  input  logic [XLEN-1:0]  dm_req_addr,
  input  logic             dm_req_wen,
  input  logic [XLEN-1:0]  dm_req_wdata,
  input  logic [BYTES-1:0] dm_req_wstrb,
  output logic             dm_resp_valid,
  input  logic             dm_resp_ready,
  output logic [XLEN-1:0]  dm_resp_rdata,
  output logic             dm_resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];
  decode_t         if_dec, dm_dec;
  logic [AW-1:0]   if_idx, dm_idx;
  logic [XLEN-1:0] if_rd, dm_rd;
  logic            if_hs, dm_hs;
  logic            unused_dec;

  assign if_dec     = addr_decode(DEC_W'(if_req_addr), DEC_W'(BASE_ADDR), DEPTH_WORDS, XLEN);
  assign dm_dec     = addr_decode(DEC_W'(dm_req_addr), DEC_W'(BASE_ADDR), DEPTH_WORDS, XLEN);
  assign if_idx     = if_dec.idx[AW-1:0];
  assign dm_idx     = dm_dec.idx[AW-1:0];
  assign unused_dec = ^{if_dec.idx[DEC_W-1:AW], dm_dec.idx[DEC_W-1:AW]};

  // Reads sample the array before this edge's write lands, giving read-before-write.
  assign if_rd = if_dec.err ? '0 : mem_q[if_idx];
  assign dm_rd = (dm_dec.err || dm_req_wen) ? '0 : mem_q[dm_idx];

  always_ff @(posedge clk) begin
    if (dm_hs && dm_req_wen && !dm_dec.err) begin
      for (int b = 0; b < BYTES; b++) begin
        if (dm_req_wstrb[b]) begin
          mem_q[dm_idx][8*b +: 8] <= dm_req_wdata[8*b +: 8];
        end
      end
    end
  end

  mem_port_fsm #(
    .XLEN    (XLEN),
    .LATENCY (LATENCY)
  ) u_if_port (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (if_req_valid),
    .req_ready_o  (if_req_ready),
    .hs_o         (if_hs),
    .rdata_i      (if_rd),
    .err_i        (if_dec.err),
    .resp_valid_o (if_resp_valid),
    .resp_ready_i (if_resp_ready),
    .resp_data_o  (if_resp_inst),
    .resp_err_o   (if_resp_err)
  );

  mem_port_fsm #(
    .XLEN    (XLEN),
    .LATENCY (LATENCY)
  ) u_dm_port (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (dm_req_valid),
    .req_ready_o  (dm_req_ready),
    .hs_o         (dm_hs),
    .rdata_i      (dm_rd),
    .err_i        (dm_dec.err),
    .resp_valid_o (dm_resp_valid),
    .resp_ready_i (dm_resp_ready),
    .resp_data_o  (dm_resp_rdata),
    .resp_err_o   (dm_resp_err)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_dualport.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_dualport : bench for mem_dualport at LATENCY 1 (dut 0) and 3 (1)  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mem_dualport;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req_valid  [2];
  logic [1:0]  if_req_ready;
  logic [31:0] if_req_addr   [2];
  logic [1:0]  if_resp_valid;
  logic        if_resp_ready [2];
  logic [31:0] if_resp_inst  [2];
  logic [1:0]  if_resp_err;
  logic        dm_req_valid  [2];
  logic [1:0]  dm_req_ready;
  logic [31:0] dm_req_addr   [2];
  logic        dm_req_wen    [2];
  logic [31:0] dm_req_wdata  [2];
  logic [3:0]  dm_req_wstrb  [2];
  logic [1:0]  dm_resp_valid;
  logic        dm_resp_ready [2];
  logic [31:0] dm_resp_rdata [2];
  logic [1:0]  dm_resp_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [2][DEPTH];
  int          lat_of  [2] = '{1, 3};

  mem_dualport #(.XLEN(32), .DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(BASE), .INIT_FILE("")) u_dut0 (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid[0]), .if_req_ready(if_req_ready[0]), .if_req_addr(if_req_addr[0]),
    .if_resp_valid(if_resp_valid[0]), .if_resp_ready(if_resp_ready[0]),
    .if_resp_inst(if_resp_inst[0]), .if_resp_err(if_resp_err[0]),
    .dm_req_valid(dm_req_valid[0]), .dm_req_ready(dm_req_ready[0]), .dm_req_addr(dm_req_addr[0]),
    .dm_req_wen(dm_req_wen[0]), .dm_req_wdata(dm_req_wdata[0]), .dm_req_wstrb(dm_req_wstrb[0]),
    .dm_resp_valid(dm_resp_valid[0]), .dm_resp_ready(dm_resp_ready[0]),
    .dm_resp_rdata(dm_resp_rdata[0]), .dm_resp_err(dm_resp_err[0])
  );

  mem_dualport #(.XLEN(32), .DEPTH_WORDS(DEPTH), .LATENCY(3), .BASE_ADDR(BASE), .INIT_FILE("")) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid[1]), .if_req_ready(if_req_ready[1]), .if_req_addr(if_req_addr[1]),
    .if_resp_valid(if_resp_valid[1]), .if_resp_ready(if_resp_ready[1]),
    .if_resp_inst(if_resp_inst[1]), .if_resp_err(if_resp_err[1]),
    .dm_req_valid(dm_req_valid[1]), .dm_req_ready(dm_req_ready[1]), .dm_req_addr(dm_req_addr[1]),
    .dm_req_wen(dm_req_wen[1]), .dm_req_wdata(dm_req_wdata[1]), .dm_req_wstrb(dm_req_wstrb[1]),
    .dm_resp_valid(dm_resp_valid[1]), .dm_resp_ready(dm_resp_ready[1]),
    .dm_resp_rdata(dm_resp_rdata[1]), .dm_resp_err(dm_resp_err[1])
  );

  // Reference model: address legality and word index straight from the address map.
  function automatic bit exp_err(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a[1:0] != 2'b00) || (off >= 32'(DEPTH * 4));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] exp_word(input int d, input logic [31:0] a);
    return exp_err(a) ? 32'h0 : ref_mem[d][widx(a)];
  endfunction

  task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    if (!exp_err(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (ws[b]) ref_mem[d][widx(a)][8*b +: 8] = wd[8*b +: 8];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dm_txn(input int d, input logic [31:0] a, input logic wen, input logic [31:0] wd,
                        input logic [3:0] ws, output logic [31:0] rd, output logic er,
                        output bit ok, output int lat);
    int n;
    ok = 1'b0; rd = '0; er = 1'b0; lat = 0;
    dm_req_addr[d] = a; dm_req_wen[d] = wen; dm_req_wdata[d] = wd; dm_req_wstrb[d] = ws;
    dm_resp_ready[d] = 1'b1; dm_req_valid[d] = 1'b1;
    n = 0;
    while (!dm_req_ready[d] && n < 20) begin tick(); n++; end
    tick();
    dm_req_valid[d] = 1'b0;
    n = 0;
    while (!dm_resp_valid[d] && n < 20) begin tick(); n++; end
    if (dm_resp_valid[d]) begin
      rd = dm_resp_rdata[d]; er = dm_resp_err[d]; ok = 1'b1; lat = n + 1;
    end
    tick();
  endtask

  task automatic if_txn(input int d, input logic [31:0] a, output logic [31:0] rd, output logic er,
                        output bit ok, output int lat);
    int n;
    ok = 1'b0; rd = '0; er = 1'b0; lat = 0;
    if_req_addr[d] = a; if_resp_ready[d] = 1'b1; if_req_valid[d] = 1'b1;
    n = 0;
    while (!if_req_ready[d] && n < 20) begin tick(); n++; end
    tick();
    if_req_valid[d] = 1'b0;
    n = 0;
    while (!if_resp_valid[d] && n < 20) begin tick(); n++; end
    if (if_resp_valid[d]) begin
      rd = if_resp_inst[d]; er = if_resp_err[d]; ok = 1'b1; lat = n + 1;
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      if_req_valid[d] = 1'b0; if_req_addr[d] = BASE; if_resp_ready[d] = 1'b1;
      dm_req_valid[d] = 1'b0; dm_req_addr[d] = BASE; dm_req_wen[d] = 1'b0;
      dm_req_wdata[d] = '0; dm_req_wstrb[d] = '0; dm_resp_ready[d] = 1'b1;
    end
    repeat (3) tick();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({if_req_ready[d], dm_req_ready[d]} !== 2'b11) begin
        errors++; $display("FAIL reset_ready[%0d]: got %b required 11", d, {if_req_ready[d], dm_req_ready[d]});
      end
      checks++;
      if ({if_resp_valid[d], dm_resp_valid[d], if_resp_err[d], dm_resp_err[d]} !== 4'b0000) begin
        errors++; $display("FAIL reset_valid_err[%0d]: got %b required 0000", d,
                           {if_resp_valid[d], dm_resp_valid[d], if_resp_err[d], dm_resp_err[d]});
      end
      checks++;
      if (if_resp_inst[d] !== 32'h0 || dm_resp_rdata[d] !== 32'h0) begin
        errors++; $display("FAIL reset_data[%0d]: inst %h rdata %h required 0", d, if_resp_inst[d], dm_resp_rdata[d]);
      end
    end
  endtask

  task automatic test_fetch_basic();
    logic [31:0] rd; logic er; bit ok; int lat;
    for (int d = 0; d < 2; d++) begin
      dm_txn(d, BASE, 1'b1, 32'h0000_0013, 4'hF, rd, er, ok, lat);
      model_write(d, BASE, 32'h0000_0013, 4'hF);
      checks++;
      if (!ok || er !== 1'b0 || rd !== 32'h0 || lat != lat_of[d]) begin
        errors++; $display("FAIL preload_write[%0d]: ok %0d err %b rdata %h lat %0d required ok err 0 rdata 0 lat %0d",
                           d, ok, er, rd, lat, lat_of[d]);
      end
    end
    if_txn(0, BASE, rd, er, ok, lat);
    checks++;
    if (!ok || lat != 1) begin
      errors++; $display("FAIL fetch_latency: ok %0d lat %0d required 1", ok, lat);
    end
    checks++;
    if (rd !== 32'h0000_0013 || er !== 1'b0) begin
      errors++; $display("FAIL fetch_word0: inst %h err %b required 00000013 err 0", rd, er);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] rd; logic er; bit ok; int lat;
    dm_txn(0, BASE + 32'h10, 1'b1, 32'h1122_3344, 4'hF, rd, er, ok, lat);
    model_write(0, BASE + 32'h10, 32'h1122_3344, 4'hF);
    dm_txn(0, BASE + 32'h10, 1'b1, 32'hAABB_CCDD, 4'b0101, rd, er, ok, lat);
    model_write(0, BASE + 32'h10, 32'hAABB_CCDD, 4'b0101);
    dm_txn(0, BASE + 32'h10, 1'b0, 32'h0, 4'h0, rd, er, ok, lat);
    checks++;
    if (!ok || rd !== 32'h11BB_33DD || er !== 1'b0) begin
      errors++; $display("FAIL strobe_merge: ok %0d rdata %h err %b required 11bb33dd err 0", ok, rd, er);
    end
    dm_txn(0, BASE + 32'h10, 1'b1, 32'hFFFF_FFFF, 4'h0, rd, er, ok, lat);
    checks++;
    if (!ok || er !== 1'b0 || rd !== 32'h0) begin
      errors++; $display("FAIL strobe_zero_resp: ok %0d err %b rdata %h required response err 0 rdata 0", ok, er, rd);
    end
    dm_txn(0, BASE + 32'h10, 1'b0, 32'h0, 4'h0, rd, er, ok, lat);
    checks++;
    if (!ok || rd !== ref_mem[0][4]) begin
      errors++; $display("FAIL strobe_zero_noop: rdata %h required %h", rd, ref_mem[0][4]);
    end
  endtask

  task automatic test_same_edge();
    logic [31:0] rd; logic er; bit ok; int lat;
    dm_txn(0, BASE + 32'h4, 1'b1, 32'h0102_0304, 4'hF, rd, er, ok, lat);
    model_write(0, BASE + 32'h4, 32'h0102_0304, 4'hF);
    if_req_addr[0] = BASE + 32'h4; if_req_valid[0] = 1'b1;
    dm_req_addr[0] = BASE + 32'h4; dm_req_wen[0] = 1'b1; dm_req_wdata[0] = 32'hDEAD_BEEF;
    dm_req_wstrb[0] = 4'hF; dm_req_valid[0] = 1'b1;
    tick();
    if_req_valid[0] = 1'b0; dm_req_valid[0] = 1'b0;
    checks++;
    if (if_resp_valid[0] !== 1'b1 || if_resp_inst[0] !== 32'h0102_0304) begin
      errors++; $display("FAIL same_edge_old: valid %b inst %h required 1 01020304", if_resp_valid[0], if_resp_inst[0]);
    end
    checks++;
    if (dm_resp_valid[0] !== 1'b1 || dm_resp_err[0] !== 1'b0 || dm_resp_rdata[0] !== 32'h0) begin
      errors++; $display("FAIL same_edge_write_resp: valid %b err %b rdata %h required 1 0 0",
                         dm_resp_valid[0], dm_resp_err[0], dm_resp_rdata[0]);
    end
    model_write(0, BASE + 32'h4, 32'hDEAD_BEEF, 4'hF);
    tick();
    if_txn(0, BASE + 32'h4, rd, er, ok, lat);
    checks++;
    if (!ok || rd !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL same_edge_new: ok %0d inst %h required deadbeef", ok, rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; bit ok; int lat;
    logic [31:0] bad_dm [2] = '{32'h8000_0002, 32'h7FFF_FFFC};
    for (int i = 0; i < 2; i++) begin
      dm_txn(0, bad_dm[i], 1'b0, 32'h0, 4'h0, rd, er, ok, lat);
      checks++;
      if (!ok || er !== 1'b1 || rd !== 32'h0) begin
        errors++; $display("FAIL err_dm_read %h: ok %0d err %b rdata %h required err 1 rdata 0", bad_dm[i], ok, er, rd);
      end
    end
    if_txn(0, 32'h8000_1000, rd, er, ok, lat);
    checks++;
    if (!ok || er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL err_if_range: ok %0d err %b inst %h required err 1 inst 0", ok, er, rd);
    end
    dm_txn(0, BASE + 32'h12, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, er, ok, lat);
    checks++;
    if (!ok || er !== 1'b1) begin
      errors++; $display("FAIL err_dm_write: ok %0d err %b required 1", ok, er);
    end
    dm_txn(0, BASE + 32'h10, 1'b0, 32'h0, 4'h0, rd, er, ok, lat);
    checks++;
    if (rd !== ref_mem[0][4] || er !== 1'b0) begin
      errors++; $display("FAIL err_no_update: rdata %h err %b required %h err 0", rd, er, ref_mem[0][4]);
    end
    dm_txn(0, BASE + 32'hFFC, 1'b1, 32'h5A5A_A5A5, 4'hF, rd, er, ok, lat);
    model_write(0, BASE + 32'hFFC, 32'h5A5A_A5A5, 4'hF);
    if_txn(0, BASE + 32'hFFC, rd, er, ok, lat);
    checks++;
    if (!ok || er !== 1'b0 || rd !== 32'h5A5A_A5A5) begin
      errors++; $display("FAIL last_word: ok %0d err %b inst %h required err 0 5a5aa5a5", ok, er, rd);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    exp = ref_mem[1][0];
    if_req_addr[1] = BASE; if_resp_ready[1] = 1'b0; if_req_valid[1] = 1'b1;
    checks++;
    if (if_req_ready[1] !== 1'b1) begin
      errors++; $display("FAIL bp_idle_ready: got %b required 1", if_req_ready[1]);
    end
    tick();
    if_req_valid[1] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (if_resp_valid[1] !== (k == 3) || if_req_ready[1] !== 1'b0) begin
        errors++; $display("FAIL bp_latency cycle %0d: valid %b ready %b required valid %0d ready 0",
                           k, if_resp_valid[1], if_req_ready[1], (k == 3));
      end
      if (k < 3) tick();
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (if_resp_valid[1] !== 1'b1 || if_resp_inst[1] !== exp || if_resp_err[1] !== 1'b0 || if_req_ready[1] !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle %0d: valid %b inst %h err %b ready %b required 1 %h 0 0",
                           k, if_resp_valid[1], if_resp_inst[1], if_resp_err[1], if_req_ready[1], exp);
      end
      tick();
    end
    if_resp_ready[1] = 1'b1;
    tick();
    checks++;
    if (if_resp_valid[1] !== 1'b0 || if_req_ready[1] !== 1'b1) begin
      errors++; $display("FAIL bp_accept: valid %b ready %b required 0 1", if_resp_valid[1], if_req_ready[1]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; bit ok; int lat;
    dm_req_addr[1] = BASE + 32'h20; dm_req_wen[1] = 1'b1; dm_req_wdata[1] = 32'hCAFE_F00D;
    dm_req_wstrb[1] = 4'hF; dm_req_valid[1] = 1'b1;
    tick();
    dm_req_valid[1] = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    model_write(1, BASE + 32'h20, 32'hCAFE_F00D, 4'hF);
    dm_req_wen[1] = 1'b0; dm_req_valid[1] = 1'b1;
    tick();
    dm_req_valid[1] = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (dm_req_ready[1] !== 1'b1) begin
      errors++; $display("FAIL rst_mid_ready: got %b required 1", dm_req_ready[1]);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (dm_resp_valid[1] !== 1'b0 || dm_resp_rdata[1] !== 32'h0) begin
        errors++; $display("FAIL rst_mid_discard cycle %0d: valid %b rdata %h required 0 0", k, dm_resp_valid[1], dm_resp_rdata[1]);
      end
      tick();
    end
    dm_txn(1, BASE + 32'h20, 1'b0, 32'h0, 4'h0, rd, er, ok, lat);
    checks++;
    if (!ok || rd !== 32'hCAFE_F00D || er !== 1'b0) begin
      errors++; $display("FAIL rst_write_kept: ok %0d rdata %h err %b required cafef00d 0", ok, rd, er);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd, exp; logic [3:0] ws; logic er; bit ok; int lat;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        wd = $urandom;
        a  = BASE + 32'(4 * i);
        dm_txn(d, a, 1'b1, wd, 4'hF, rd, er, ok, lat);
        model_write(d, a, wd, 4'hF);
      end
    end
    for (int n = 0; n < 80; n++) begin
      int d;
      int op;
      d  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0:       a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
          1:       a = BASE - 32'(4 * $urandom_range(1, 8));
          default: a = BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 8));
        endcase
      end else begin
        a = BASE + 32'(4 * $urandom_range(0, 15));
      end
      if (op == 2) begin
        wd = $urandom;
        ws = 4'($urandom_range(0, 15));
        dm_txn(d, a, 1'b1, wd, ws, rd, er, ok, lat);
        model_write(d, a, wd, ws);
        exp = 32'h0;
      end else begin
        exp = exp_word(d, a);
        if (op == 0) if_txn(d, a, rd, er, ok, lat);
        else         dm_txn(d, a, 1'b0, 32'h0, 4'h0, rd, er, ok, lat);
      end
      checks++;
      if (!ok || rd !== exp || er !== exp_err(a) || lat != lat_of[d]) begin
        errors++; $display("FAIL random #%0d dut%0d op%0d addr %h: ok %0d data %h err %b lat %0d required %h %b %0d",
                           n, d, op, a, ok, rd, er, lat, exp, exp_err(a), lat_of[d]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fetch_basic();
    test_strobe();
    test_same_edge();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
